fetch_decode_stage: RTL and testbench

Pipeline stage directly downstream of the instruction getter in the decryption processor. Captures each 32-bit word from the getter, decodes it into registered control and operand fields for execute, and tracks the PC of every word. Resolves unconditional jumps locally and relays execute-stage flushes. Redirects drive the getter's parallelFlag/parallelAddress, and wrong-path words are squashed.

---
 rtl/decrypt_pkg.sv | 48 ++++
 rtl/instruction_field_decoder.sv | 53 +++++
 rtl/fetch_decode_stage.sv | 165 ++++++++++++++++
 tb/tb_fetch_decode_stage.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/decrypt_pkg.sv
// Shared types for the decryption processor front end: opcode map, stage FSM
// states, instruction field positions and the decoded control bundle.
package decrypt_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_ADD   = 4'h1,
    OP_SUB   = 4'h2,
    OP_AND   = 4'h3,
    OP_OR    = 4'h4,
    OP_XOR   = 4'h5,
    OP_SHL   = 4'h6,
    OP_SHR   = 4'h7,
    OP_ADDI  = 4'h8,
    OP_XORI  = 4'h9,
    OP_LOAD  = 4'hA,
    OP_STORE = 4'hB,
    OP_BEQ   = 4'hC,
    OP_JMP   = 4'hD,
    OP_RSV_E = 4'hE,
    OP_RSV_F = 4'hF
  } opcode_t;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } state_t;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 28;
  localparam int RD_MSB  = 27;
  localparam int RD_LSB  = 24;
  localparam int RS1_MSB = 23;
  localparam int RS1_LSB = 20;
  localparam int RS2_MSB = 19;
  localparam int RS2_LSB = 16;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef struct packed {
    logic regWrite;
    logic memRead;
    logic memWrite;
    logic useImm;
    logic branch;
  } ctrl_t;

endpackage

// File: rtl/instruction_field_decoder.sv
// Combinational split of a 32-bit word into opcode, register fields,
// sign-extended immediate and control bits.
module instruction_field_decoder
  import decrypt_pkg::*;
(
  input  logic [31:0] instruction,
  output opcode_t     opcode,
  output logic [3:0]  rd,
  output logic [3:0]  rs1,
  output logic [3:0]  rs2,
  output logic [31:0] imm,
  output ctrl_t       ctrl,
  output logic        illegal,
  output logic        is_jmp
);

  assign opcode = opcode_t'(instruction[OPC_MSB:OPC_LSB]);
  assign rd     = instruction[RD_MSB:RD_LSB];
  assign rs1    = instruction[RS1_MSB:RS1_LSB];
  assign rs2    = instruction[RS2_MSB:RS2_LSB];
  assign imm    = {{16{instruction[IMM_MSB]}}, instruction[IMM_MSB:IMM_LSB]};

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    is_jmp  = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR:
        ctrl.regWrite = 1'b1;
      OP_ADDI, OP_XORI: begin
        ctrl.regWrite = 1'b1;
        ctrl.useImm   = 1'b1;
      end
      OP_LOAD: begin
        ctrl.regWrite = 1'b1;
        ctrl.memRead  = 1'b1;
        ctrl.useImm   = 1'b1;
      end
      OP_STORE: begin
        ctrl.memWrite = 1'b1;
        ctrl.useImm   = 1'b1;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.useImm = 1'b1;
      end
      OP_JMP:             is_jmp  = 1'b1;
      OP_RSV_E, OP_RSV_F: illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_decode_stage.sv
// Fetch/decode stage: registers decoded fields for execute, tracks the PC,
// resolves JMP locally, relays execute flushes and squashes wrong-path words.
module fetch_decode_stage
  import decrypt_pkg::*;
#(
  parameter int SQUASH_CYCLES = 2,
  parameter int ADDR_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instruction,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flushAddress,
  output logic              parallelFlag,
  output logic [ADDR_W-1:0] parallelAddress,
  output logic              valid,
  output logic [3:0]        opcode,
  output logic [3:0]        rd,
  output logic [3:0]        rs1,
  output logic [3:0]        rs2,
  output logic [31:0]       imm,
  output logic              regWrite,
  output logic              memRead,
  output logic              memWrite,
  output logic              useImm,
  output logic              branch,
  output logic              illegal,
  output logic [ADDR_W-1:0] pcOut
);

  localparam logic [2:0]        SQ_INIT = 3'(SQUASH_CYCLES);
  localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  opcode_t     dec_opcode;
  logic [3:0]  dec_rd, dec_rs1, dec_rs2;
  logic [31:0] dec_imm;
  ctrl_t       dec_ctrl;
  logic        dec_illegal, dec_jmp;

  instruction_field_decoder u_dec (
    .instruction (instruction),
    .opcode      (dec_opcode),
    .rd          (dec_rd),
    .rs1         (dec_rs1),
    .rs2         (dec_rs2),
    .imm         (dec_imm),
    .ctrl        (dec_ctrl),
    .illegal     (dec_illegal),
    .is_jmp      (dec_jmp)
  );

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  logic              pflag_q, pflag_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              valid_q, valid_d;
  logic [3:0]        opc_q, opc_d;
  logic [3:0]        rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [31:0]       imm_q, imm_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic              ill_q, ill_d;
  logic [ADDR_W-1:0] pco_q, pco_d;

  // Priority: flush > squash > JMP > normal decode. Non-valid cycles drive
  // every decoded field to zero so nothing stale leaks into execute.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    pflag_d = 1'b0;
    paddr_d = paddr_q;
    valid_d = 1'b0;
    opc_d   = '0;
    rd_d    = '0;
    rs1_d   = '0;
    rs2_d   = '0;
    imm_d   = '0;
    ctrl_d  = '0;
    ill_d   = 1'b0;
    pco_d   = '0;
    if (flush) begin
      pflag_d = 1'b1;
      paddr_d = flushAddress;
      state_d = SQUASH;
      cnt_d   = SQ_INIT;
      pc_d    = flushAddress;
    end else if (state_q == SQUASH) begin
      cnt_d = cnt_q - 3'd1;
      if (cnt_q <= 3'd1) begin
        cnt_d   = '0;
        state_d = RUN;
      end
    end else if (dec_jmp) begin
      pflag_d = 1'b1;
      paddr_d = dec_imm[ADDR_W-1:0];
      state_d = SQUASH;
      cnt_d   = SQ_INIT;
      pc_d    = dec_imm[ADDR_W-1:0];
    end else begin
      valid_d = 1'b1;
      opc_d   = dec_opcode;
      rd_d    = dec_rd;
      rs1_d   = dec_rs1;
      rs2_d   = dec_rs2;
      imm_d   = dec_imm;
      ctrl_d  = dec_ctrl;
      ill_d   = dec_illegal;
      pco_d   = pc_q;
      pc_d    = pc_q + PC_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SQUASH;
      cnt_q   <= SQ_INIT;
      pc_q    <= '0;
      pflag_q <= 1'b0;
      paddr_q <= '0;
      valid_q <= 1'b0;
      opc_q   <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      ctrl_q  <= '0;
      ill_q   <= 1'b0;
      pco_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      pflag_q <= pflag_d;
      paddr_q <= paddr_d;
      valid_q <= valid_d;
      opc_q   <= opc_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
      ctrl_q  <= ctrl_d;
      ill_q   <= ill_d;
      pco_q   <= pco_d;
    end
  end

  assign parallelFlag    = pflag_q;
  assign parallelAddress = paddr_q;
  assign valid           = valid_q;
  assign opcode          = opc_q;
  assign rd              = rd_q;
  assign rs1             = rs1_q;
  assign rs2             = rs2_q;
  assign imm             = imm_q;
  assign regWrite        = ctrl_q.regWrite;
  assign memRead         = ctrl_q.memRead;
  assign memWrite        = ctrl_q.memWrite;
  assign useImm          = ctrl_q.useImm;
  assign branch          = ctrl_q.branch;
  assign illegal         = ill_q;
  assign pcOut           = pco_q;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage with hand-computed expectations.
module tb_fetch_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        flush;
  logic [7:0]  flushAddress;
  logic        parallelFlag;
  logic [7:0]  parallelAddress;
  logic        valid;
  logic [3:0]  opcode, rd, rs1, rs2;
  logic [31:0] imm;
  logic        regWrite, memRead, memWrite, useImm, branch, illegal;
  logic [7:0]  pcOut;

  int tests = 0;
  int fails = 0;

  fetch_decode_stage #(.SQUASH_CYCLES(2), .ADDR_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .instruction     (instruction),
    .flush           (flush),
    .flushAddress    (flushAddress),
    .parallelFlag    (parallelFlag),
    .parallelAddress (parallelAddress),
    .valid           (valid),
    .opcode          (opcode),
    .rd              (rd),
    .rs1             (rs1),
    .rs2             (rs2),
    .imm             (imm),
    .regWrite        (regWrite),
    .memRead         (memRead),
    .memWrite        (memWrite),
    .useImm          (useImm),
    .branch          (branch),
    .illegal         (illegal),
    .pcOut           (pcOut)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] ADD  = 32'h1123_0000;
  localparam logic [31:0] ADDI = 32'h8120_FFFF;
  localparam logic [31:0] LOAD = 32'hA340_0010;
  localparam logic [31:0] JMP40 = 32'hD000_0040;
  localparam logic [31:0] JMPFE = 32'hD000_00FE;
  localparam logic [31:0] RSVE = 32'hE000_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs, cross the edge, sample 1 time unit later.
  task automatic step(input logic r, input logic [31:0] ins, input logic f, input logic [7:0] fa);
    rst = r; instruction = ins; flush = f; flushAddress = fa;
    @(posedge clk);
    #1;
  endtask

  // Packs control outputs as {valid, regWrite, memRead, memWrite, useImm, branch, illegal, parallelFlag}.
  function automatic logic [31:0] ctl();
    return {24'd0, valid, regWrite, memRead, memWrite, useImm, branch, illegal, parallelFlag};
  endfunction

  initial begin
    rst = 1'b1; instruction = '0; flush = 1'b0; flushAddress = '0;
    step(1, ADD, 0, 0);
    step(1, ADD, 0, 0);
    chk("reset_ctl", ctl(), 32'h00);
    chk("reset_pc", {24'd0, pcOut}, 32'h0);
    chk("reset_fields", {opcode, rd, rs1, rs2, 16'd0}, 32'h0);
    chk("reset_imm", imm, 32'h0);

    // startup squash then ADD stream at pc 0..3
    step(0, ADD, 0, 0);
    chk("startup_sq0", ctl(), 32'h00);
    step(0, ADD, 0, 0);
    chk("startup_sq1", ctl(), 32'h00);
    for (int i = 0; i < 4; i++) begin
      step(0, ADD, 0, 0);
      chk("add_ctl", ctl(), 32'hC0);
      chk("add_pc", {24'd0, pcOut}, i);
    end
    chk("add_fields", {16'd0, opcode, rd, rs1, rs2}, 32'h1123);

    step(0, ADDI, 0, 0);
    chk("addi_imm", imm, 32'hFFFF_FFFF);
    chk("addi_ctl", ctl(), 32'hC8);
    chk("addi_pc", {24'd0, pcOut}, 32'h4);

    // JMP at pc 5
    step(0, JMP40, 0, 0);
    chk("jmp_ctl", ctl(), 32'h01);
    chk("jmp_addr", {24'd0, parallelAddress}, 32'h40);
    step(0, ADD, 0, 0);
    chk("jmp_drop0", ctl(), 32'h00);
    step(0, ADD, 0, 0);
    chk("jmp_drop1", ctl(), 32'h00);
    step(0, LOAD, 0, 0);
    chk("load_ctl", ctl(), 32'hE8);
    chk("load_imm", imm, 32'h10);
    chk("load_pc", {24'd0, pcOut}, 32'h40);
    chk("load_fields", {16'd0, opcode, rd, rs1, rs2}, 32'hA340);

    // flush beats a simultaneous JMP, then a second flush mid-squash
    step(0, JMP40, 1, 8'h20);
    chk("flush_ctl", ctl(), 32'h01);
    chk("flush_addr", {24'd0, parallelAddress}, 32'h20);
    step(0, ADD, 0, 0);
    chk("flush_drop0", ctl(), 32'h00);
    step(0, ADD, 1, 8'h30);
    chk("reflush_ctl", ctl(), 32'h01);
    chk("reflush_addr", {24'd0, parallelAddress}, 32'h30);
    step(0, ADD, 0, 0);
    chk("reflush_drop0", ctl(), 32'h00);
    step(0, ADD, 0, 0);
    chk("reflush_drop1", ctl(), 32'h00);
    step(0, RSVE, 0, 0);
    chk("illegal_ctl", ctl(), 32'h82);
    chk("illegal_pc", {24'd0, pcOut}, 32'h30);
    chk("illegal_opc", {28'd0, opcode}, 32'hE);
    step(0, 32'h0, 0, 0);
    chk("nop_ctl", ctl(), 32'h80);
    chk("nop_pc", {24'd0, pcOut}, 32'h31);

    // wrap 0xFE, 0xFF, 0x00
    step(0, JMPFE, 0, 0);
    chk("jmpfe_addr", {24'd0, parallelAddress}, 32'hFE);
    step(0, ADD, 0, 0);
    step(0, ADD, 0, 0);
    chk("jmpfe_drop1", ctl(), 32'h00);
    step(0, ADD, 0, 0);
    chk("wrap_pc0", {24'd0, pcOut}, 32'hFE);
    step(0, ADD, 0, 0);
    chk("wrap_pc1", {24'd0, pcOut}, 32'hFF);
    step(0, ADD, 0, 0);
    chk("wrap_pc2", {24'd0, pcOut}, 32'h00);
    chk("wrap_valid", ctl(), 32'hC0);

    // reset during RUN
    step(1, ADD, 0, 0);
    chk("rst_run_ctl", ctl(), 32'h00);
    chk("rst_run_fields", {opcode, rd, rs1, rs2, 8'd0, pcOut}, 32'h0);
    step(0, ADD, 0, 0);
    // reset during SQUASH
    step(1, ADD, 0, 0);
    chk("rst_sq_ctl", ctl(), 32'h00);
    chk("rst_sq_paddr", {24'd0, parallelAddress}, 32'h0);
    step(0, ADD, 0, 0);
    chk("restart_sq0", ctl(), 32'h00);
    step(0, ADD, 0, 0);
    chk("restart_sq1", ctl(), 32'h00);
    step(0, ADD, 0, 0);
    chk("restart_ctl", ctl(), 32'hC0);
    chk("restart_pc", {24'd0, pcOut}, 32'h0);
    step(0, ADD, 0, 0);
    chk("restart_pc1", {24'd0, pcOut}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
